// File: rtl/dac_feeder.sv
// Sample-rate paced feeder: buffers signed PCM, emits one offset-binary DAC word per period.
// Build option DAC_FEEDER_HOLD_LAST_EN: on underflow repeat the previous word instead of midscale.

module dac_feeder #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CLK_DIV    = 1134,
    parameter int unsigned SPI_CYCLES = 36,
    parameter logic [3:0]  DAC_CMD    = 4'b0011
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [15:0]            wr_data,
    output logic                   wr,
    output logic                   underflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned GRD_W = $clog2(SPI_CYCLES + 1);

    localparam logic [15:0] MIDSCALE = {DAC_CMD, 12'h800};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pending_q, pending_d;
    logic [1:0]       state_q, state_d;
    logic [GRD_W-1:0] guard_q, guard_d;
    logic             uf_flag_q, uf_flag_d;
    logic [15:0]      wr_data_q, wr_data_d;

    logic        tick;
    logic        push;
    logic        pop;
    logic        service;
    logic        fifo_empty;
    logic [15:0] head;
    logic [11:0] code;
    logic [15:0] under_word;
    logic        unused_lsbs;

    // FIFO handshake and occupancy
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q < CNT_W'(DEPTH)) && !rst;
    assign push       = in_valid && in_ready;
    assign service    = (state_q == ST_IDLE) && (tick || pending_q);
    assign pop        = service && !fifo_empty;

    assign head        = mem[rd_ptr_q];
    assign code        = {~head[15], head[14:4]};
    // Low four sample bits are dropped by truncation.
    assign unused_lsbs = ^head[3:0];

`ifdef DAC_FEEDER_HOLD_LAST_EN
    assign under_word = wr_data_q;
`else
    assign under_word = MIDSCALE;
`endif

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A tick that lands while busy waits here; further ticks are absorbed.
    always_comb begin
        pending_d = pending_q;
        if (service) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        uf_flag_d = uf_flag_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (service) begin
                    wr_data_d = fifo_empty ? under_word : {DAC_CMD, code};
                    uf_flag_d = fifo_empty;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                uf_flag_d = 1'b0;
                guard_d   = '0;
                state_d   = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_q == GRD_W'(SPI_CYCLES - 1)) begin
                    guard_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GRD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            div_q     <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_IDLE;
            guard_q   <= '0;
            uf_flag_q <= 1'b0;
            wr_data_q <= MIDSCALE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            guard_q   <= guard_d;
            uf_flag_q <= uf_flag_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr        = (state_q == ST_SEND);
    assign underflow = wr && uf_flag_q;
    assign wr_data   = wr_data_q;
    assign level     = count_q;

endmodule

// File: tb/tb_dac_feeder.sv
// Self-checking bench for dac_feeder: vector table plus scoreboard of expected DAC strobes.
// Underflow expectations follow the DAC_FEEDER_HOLD_LAST_EN build macro.

module tb_dac_feeder;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned CLK_DIV    = 40;
    localparam int unsigned SPI_CYCLES = 20;
    localparam logic [3:0]  DAC_CMD    = 4'b0011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] wr_data;
    logic        wr;
    logic        underflow;
    logic [3:0]  level;

    dac_feeder #(
        .DEPTH      (DEPTH),
        .CLK_DIV    (CLK_DIV),
        .SPI_CYCLES (SPI_CYCLES),
        .DAC_CMD    (DAC_CMD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_data   (wr_data),
        .wr        (wr),
        .underflow (underflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sample;
        logic [15:0] word;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic        uf;
    } exp_t;

    vec_t        vecs [6];
    exp_t        exp_q [$];
    int          strobe_q [$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rel0 = 0;
    int          acc = 0;
    logic [15:0] uf_after_max;
    logic [15:0] s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Offset binary is the signed value plus half range, computed arithmetically.
    function automatic logic [15:0] ref_word(input logic [15:0] smp);
        logic [15:0] u;
        u = smp + 16'h8000;
        return {DAC_CMD, u[15:4]};
    endfunction

    // Every strobe is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            strobe_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got wr_data=%h, required no strobe (cycle %0d)",
                         wr_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk16("strobe_word", wr_data, mon_e.word);
                chk1("strobe_underflow", underflow, mon_e.uf);
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        strobe_q.delete();
        repeat (n) @(negedge clk);
        chk1("rst_wr", wr, 1'b0);
        chk1("rst_underflow", underflow, 1'b0);
        chki("rst_level", int'(level), 0);
        chk16("rst_wr_data", wr_data, 16'h3800);
        chk1("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        rel0 = cyc;
        #1;
        chk1("release_in_ready", in_ready, 1'b1);
    endtask

    task automatic push(input logic [15:0] smp, input logic [15:0] w, output int at);
        bit ok = 1'b0;
        at = -1;
        in_data = smp;
        in_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for 400 cycles, required 1");
        end else begin
            at = cyc;
            exp_q.push_back('{word: w, uf: 1'b0});
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string name, input int req_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (strobe_q.size() != 0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no strobe in 200 cycles, required one at cycle %0d",
                     name, req_cyc);
        end else begin
            chki(name, strobe_q.pop_front(), req_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{sample: 16'h0000, word: 16'h3800};
        vecs[1] = '{sample: 16'h7FFF, word: 16'h3FFF};
        vecs[2] = '{sample: 16'h8000, word: 16'h3000};
        vecs[3] = '{sample: 16'h1234, word: 16'h3923};
        vecs[4] = '{sample: 16'hFFFF, word: 16'h37FF};
        vecs[5] = '{sample: 16'h000F, word: 16'h3800};
`ifdef DAC_FEEDER_HOLD_LAST_EN
        uf_after_max = 16'h3FFF;
`else
        uf_after_max = 16'h3800;
`endif

        // Idle with nothing queued: underflow strobes at the sample rate.
        do_reset(2);
        exp_q.push_back('{word: 16'h3800, uf: 1'b1});
        exp_q.push_back('{word: 16'h3800, uf: 1'b1});
        wait_strobe("first_tick_cycle", rel0 + 40);
        wait_strobe("idle_strobe_spacing", rel0 + 80);

        // Conversion table.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].sample, vecs[i].word, acc);
        end
        for (int i = 0; i < 6; i++) begin
            wait_strobe("conv_strobe_cycle", rel0 + 40 * (i + 1));
        end
        chki("conv_level_drained", int'(level), 0);

        // Fill to full, ninth sample held off until the first pop.
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            s = 16'(i * 7989 + 291);
            push(s, ref_word(s), acc);
            chki("fill_accept_cycle", acc, rel0 + i);
        end
        chk1("full_in_ready", in_ready, 1'b0);
        chki("full_level", int'(level), 8);
        s = 16'(8 * 7989 + 291);
        push(s, ref_word(s), acc);
        chki("ninth_accept_cycle", acc, rel0 + 40);
        for (int i = 0; i < 9; i++) begin
            wait_strobe("full_drain_cycle", rel0 + 40 * (i + 1));
        end
        chki("full_level_drained", int'(level), 0);

        // Underflow right after a full-scale sample.
        do_reset(2);
        push(16'h7FFF, 16'h3FFF, acc);
        exp_q.push_back('{word: uf_after_max, uf: 1'b1});
        wait_strobe("max_strobe_cycle", rel0 + 40);
        wait_strobe("uf_after_max_cycle", rel0 + 80);

        // Reset during the guard interval with three samples queued.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            s = 16'(16'h1000 * (i + 1));
            push(s, ref_word(s), acc);
        end
        wait_strobe("pre_reset_strobe", rel0 + 40);
        repeat (5) @(negedge clk);
        #1;
        chki("guard_level", int'(level), 3);
        do_reset(1);
        exp_q.push_back('{word: 16'h3800, uf: 1'b1});
        wait_strobe("post_reset_strobe", rel0 + 40);

        // Push into an empty FIFO in the tick cycle itself.
        do_reset(2);
        repeat (39) @(negedge clk);
        #1;
        exp_q.push_back('{word: 16'h3800, uf: 1'b1});
        push(16'h4560, ref_word(16'h4560), acc);
        chki("tick_push_accept", acc, rel0 + 39);
        wait_strobe("tick_push_uf_strobe", rel0 + 40);
        chki("tick_push_level", int'(level), 1);
        wait_strobe("tick_push_sample_strobe", rel0 + 80);
        chki("tick_push_level_drained", int'(level), 0);

        repeat (3) @(negedge clk);
        #1;
        chki("scoreboard_drained", exp_q.size(), 0);
        chki("strobes_accounted", strobe_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
